// File: rtl/sim_run_controller.sv
// -----------------------------------------------------------------------------
// sim_run_controller
//
// Run controller for the single-cycle RISC-V core. It sits between the
// top-level clock/reset and the core's reset input and:
//   - holds the core's active-low reset for RST_CYCLES cycles after a launch,
//   - releases the core and counts run cycles and retired instructions,
//   - ends the run on a halt request (DONE) or on the cycle limit (TIMEOUT),
//   - reports done/timeout/pass and the latched exit code.
//
// Parameters:
//   RST_CYCLES  cycles core_rst_n is held low before the run starts (>= 1)
//   MAX_CYCLES  run-window limit in cycles, 0 = unlimited
//   CNT_W       width of cycle_count / retire_count
//   CODE_W      width of halt_code / exit_code
//   PASS_CODE   halt_code value that means pass
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high controller reset
//   start         in   launch pulse, honoured in IDLE, DONE and TIMEOUT
//   halt_req      in   core asks to stop (e.g. store to tohost)
//   halt_code     in   exit value, valid with halt_req
//   instr_retire  in   core retired one instruction this cycle
//   core_rst_n    out  registered active-low reset to the core
//   running       out  high while in RUN
//   done          out  sticky, run ended by halt_req
//   timeout       out  sticky, run ended by the cycle limit
//   pass          out  sticky, done with exit_code == PASS_CODE
//   exit_code     out  latched halt_code
//   cycle_count   out  cycles spent in RUN (saturating)
//   retire_count  out  retired instructions during RUN (saturating)
//   state_dbg     out  current FSM state encoding, for debug/checkers
//
// Optional feature (compile-time macro SIM_RUN_AUTO_START_EN):
//   defined   - the controller leaves IDLE on the first cycle after rst
//               drops, as if start had been pulsed.
//   undefined - the controller waits in IDLE for start.
//
// Handshake semantics: there is no valid/ready pair. start, halt_req and
// instr_retire are single-cycle qualifiers sampled on every rising edge; a
// high level is one event per cycle. halt_code is only looked at in a cycle
// where halt_req is high and the controller is in RUN. Inputs that arrive in
// a state that does not honour them are dropped, never queued.
// -----------------------------------------------------------------------------
module sim_run_controller #(
  parameter int unsigned        RST_CYCLES = 5,
  parameter int unsigned        MAX_CYCLES = 55,
  parameter int unsigned        CNT_W      = 32,
  parameter int unsigned        CODE_W     = 32,
  parameter logic [CODE_W-1:0]  PASS_CODE  = CODE_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic [CODE_W-1:0] halt_code,
  input  logic              instr_retire,
  output logic              core_rst_n,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic              pass,
  output logic [CODE_W-1:0] exit_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  // Hold counter only needs to reach RST_CYCLES-1.
  localparam int unsigned      HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  // The limit fires in the RUN cycle whose count is MAX_CYCLES-1, so the
  // final edge leaves cycle_count at exactly MAX_CYCLES.
  localparam logic [CNT_W-1:0] LIMIT_LAST =
    CNT_W'((MAX_CYCLES == 0) ? 0 : (MAX_CYCLES - 1));
  localparam bit               LIMIT_EN  = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_t            state;
  state_t            state_n;
  logic [HOLD_W-1:0] hold_cnt;

  logic launch;     // entering RESET this edge: clear all results
  logic hold_last;  // last cycle of the core reset hold
  logic limit_hit;  // this RUN cycle is the final one of the window
  logic auto_go;    // self-launch request while parked in IDLE

`ifdef SIM_RUN_AUTO_START_EN
  // IDLE is only reachable through rst, so being in IDLE with rst low means
  // rst has just dropped: launch on that first cycle.
  assign auto_go = 1'b1;
`else
  assign auto_go = 1'b0;
`endif

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n   = state;
    launch    = 1'b0;
    hold_last = (hold_cnt == HOLD_LAST);
    limit_hit = LIMIT_EN && (cycle_count == LIMIT_LAST);

    unique case (state)
      S_IDLE: begin
        if (start || auto_go) begin
          launch  = 1'b1;
          state_n = S_RESET;
        end
      end
      S_RESET: begin
        // start/halt/retire are deliberately ignored while the core is held.
        if (hold_last) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        // A halt in the limit cycle wins over the timeout.
        if (halt_req) begin
          state_n = S_DONE;
        end else if (limit_hit) begin
          state_n = S_TIMEOUT;
        end
      end
      S_DONE, S_TIMEOUT: begin
        if (start) begin
          launch  = 1'b1;
          state_n = S_RESET;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt     <= '0;
      core_rst_n   <= 1'b0;
      running      <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      pass         <= 1'b0;
      exit_code    <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
    end else begin
      // The core is out of reset exactly while the next state is RUN, which
      // makes core_rst_n/running registered and edge-aligned with the state.
      core_rst_n <= (state_n == S_RUN);
      running    <= (state_n == S_RUN);

      if (launch) begin
        hold_cnt     <= '0;
        done         <= 1'b0;
        timeout      <= 1'b0;
        pass         <= 1'b0;
        exit_code    <= '0;
        cycle_count  <= '0;
        retire_count <= '0;
      end else begin
        unique case (state)
          S_RESET: begin
            if (!hold_last) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          S_RUN: begin
            // Both counters saturate rather than wrap.
            if (cycle_count != CNT_SAT) begin
              cycle_count <= cycle_count + 1'b1;
            end
            // A retire in the halt cycle still counts.
            if (instr_retire && (retire_count != CNT_SAT)) begin
              retire_count <= retire_count + 1'b1;
            end
            if (halt_req) begin
              done      <= 1'b1;
              exit_code <= halt_code;
              pass      <= (halt_code == PASS_CODE);
            end else if (limit_hit) begin
              timeout <= 1'b1;
            end
          end
          default: begin
            // IDLE/DONE/TIMEOUT without launch: results frozen.
          end
        endcase
      end
    end
  end

endmodule
